pq_request_sequencer: RTL and testbench

// Front-end stage sitting directly upstream of the register-tree priority queue (max at root).

---
 rtl/pq_pkg.sv | 29 ++
 rtl/pq_sync_fifo.sv | 61 ++++++
 rtl/pq_request_sequencer.sv | 144 ++++++++++++++
 tb/tb_pq_request_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// ============================================================================
// pq_pkg : shared types for the priority-queue request front end
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pq_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_ENQUEUE = 2'd1,
    OP_DEQUEUE = 2'd2,
    OP_REPLACE = 2'd3
  } pq_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } pq_seq_state_t;

  // Counter width able to hold the value SETTLE_CYCLES itself.
  function automatic int settle_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pq_sync_fifo.sv
// ============================================================================
// pq_sync_fifo : registered show-ahead FIFO with full/empty/count
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pq_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   i_push,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_pop,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int                c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_depth  = (c_addr_w + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == c_depth);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/pq_request_sequencer.sv
// ============================================================================
// pq_request_sequencer : buffers client requests and issues paced ops to the
//                        register-tree priority queue, fusing enq+deq into REPLACE
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pq_request_sequencer
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ENQ_FIFO_DEPTH = 4,
  parameter int SETTLE_CYCLES  = 5
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_enq_valid,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  output logic                  o_enq_ready,
  input  logic                  i_deq_valid,
  output logic                  o_deq_ready,
  output logic                  o_deq_valid,
  output logic [DATA_WIDTH-1:0] o_deq_data,
  input  logic                  i_deq_ready,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic                  o_busy
);

  localparam int                  c_settle_w    = settle_w(SETTLE_CYCLES);
  localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES);

  pq_seq_state_t                 r_state;
  pq_seq_state_t                 w_next_state;
  pq_op_t                        r_op;
  pq_op_t                        w_sel_op;
  logic [c_settle_w-1:0]         r_settle_cnt;
  logic                          r_deq_pending;
  logic                          r_deq_valid;
  logic [DATA_WIDTH-1:0]         r_deq_data;

  logic [DATA_WIDTH-1:0]         w_fifo_head;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [$clog2(ENQ_FIFO_DEPTH):0] w_fifo_count;
  logic                          w_fifo_has_data;
  logic                          w_enq_fire;
  logic                          w_deq_fire;
  logic                          w_fifo_pop;

  pq_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (ENQ_FIFO_DEPTH)
  ) u_enq_fifo (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_push  (w_enq_fire),
    .i_data  (i_enq_data),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_fifo_has_data = (w_fifo_count != '0);
  assign o_enq_ready     = !w_fifo_full;
  assign o_deq_ready     = !r_deq_pending && !r_deq_valid;
  assign w_enq_fire      = i_enq_valid && o_enq_ready;
  assign w_deq_fire      = i_deq_valid && o_deq_ready;
  assign w_fifo_pop      = o_pq_wrt && !w_fifo_empty;
  assign o_pq_data       = w_fifo_head;
  assign o_deq_valid     = r_deq_valid;
  assign o_deq_data      = r_deq_data;

  // Op choice looks only at registered state, so it is stable across IDLE.
  always_comb begin
    w_sel_op = OP_NONE;
    if (w_fifo_has_data && r_deq_pending && !i_pq_empty)
      w_sel_op = OP_REPLACE;
    else if (w_fifo_has_data && !i_pq_full)
      w_sel_op = OP_ENQUEUE;
    else if (r_deq_pending && !i_pq_empty && !w_fifo_has_data)
      w_sel_op = OP_DEQUEUE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_sel_op != OP_NONE) w_next_state = ISSUE;
      ISSUE:   w_next_state = SETTLE;
      SETTLE:  if (r_settle_cnt <= c_settle_w'(1)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_pq_wrt  = (r_state == ISSUE) && ((r_op == OP_ENQUEUE) || (r_op == OP_REPLACE));
    o_pq_read = (r_state == ISSUE) && ((r_op == OP_DEQUEUE) || (r_op == OP_REPLACE));
    o_busy    = (r_state != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_op          <= OP_NONE;
      r_settle_cnt  <= '0;
      r_deq_pending <= 1'b0;
      r_deq_valid   <= 1'b0;
      r_deq_data    <= '0;
    end else begin
      if (r_state == IDLE) r_op <= w_sel_op;

      if (r_state == ISSUE)
        r_settle_cnt <= c_settle_load;
      else if ((r_state == SETTLE) && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - c_settle_w'(1);

      if (w_deq_fire)
        r_deq_pending <= 1'b1;
      else if (o_pq_read)
        r_deq_pending <= 1'b0;

      // The old root is still on i_pq_data during the issue cycle.
      if (o_pq_read) begin
        r_deq_valid <= 1'b1;
        r_deq_data  <= i_pq_data;
      end else if (r_deq_valid && i_deq_ready) begin
        r_deq_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pq_request_sequencer.sv
// ============================================================================
// tb_pq_request_sequencer : directed bench with a behavioural 8-entry max queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pq_request_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        i_enq_valid;
  logic [15:0] i_enq_data;
  logic        o_enq_ready;
  logic        i_deq_valid;
  logic        o_deq_ready;
  logic        o_deq_valid;
  logic [15:0] o_deq_data;
  logic        i_deq_ready;
  logic        o_pq_wrt;
  logic        o_pq_read;
  logic [15:0] o_pq_data;
  logic        i_pq_full;
  logic        i_pq_empty;
  logic [15:0] i_pq_data;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pq_request_sequencer #(
    .DATA_WIDTH     (16),
    .ENQ_FIFO_DEPTH (4),
    .SETTLE_CYCLES  (5)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .i_enq_valid (i_enq_valid),
    .i_enq_data  (i_enq_data),
    .o_enq_ready (o_enq_ready),
    .i_deq_valid (i_deq_valid),
    .o_deq_ready (o_deq_ready),
    .o_deq_valid (o_deq_valid),
    .o_deq_data  (o_deq_data),
    .i_deq_ready (i_deq_ready),
    .o_pq_wrt    (o_pq_wrt),
    .o_pq_read   (o_pq_read),
    .o_pq_data   (o_pq_data),
    .i_pq_full   (i_pq_full),
    .i_pq_empty  (i_pq_empty),
    .i_pq_data   (i_pq_data),
    .o_busy      (o_busy)
  );

  // Behavioural max-queue, 8 entries, root visible on i_pq_data.
  logic [15:0] qmem    [8];
  logic [15:0] qmem_nx [8];
  int          qcnt;
  int          qcnt_nx;
  logic [15:0] qmax;
  int          qmi;

  always_comb begin
    qmax = '0;
    qmi  = 0;
    for (int i = 0; i < 8; i++)
      if (i < qcnt && qmem[i] > qmax) begin
        qmax = qmem[i];
        qmi  = i;
      end
  end

  always_comb begin
    qmem_nx = qmem;
    qcnt_nx = qcnt;
    if (o_pq_read && qcnt > 0) begin
      qmem_nx[qmi] = qmem[qcnt-1];
      qcnt_nx      = qcnt - 1;
    end
    if (o_pq_wrt && qcnt_nx < 8) begin
      qmem_nx[qcnt_nx] = o_pq_data;
      qcnt_nx          = qcnt_nx + 1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) qcnt <= 0;
    else       qcnt <= qcnt_nx;
  end

  always_ff @(posedge CLK) qmem <= qmem_nx;

  assign i_pq_full  = (qcnt == 8);
  assign i_pq_empty = (qcnt == 0);
  assign i_pq_data  = qmax;

  // ---------------- stimulus helpers ----------------
  task automatic enq(input logic [15:0] v);
    i_enq_valid = 1'b1;
    i_enq_data  = v;
    @(posedge CLK); #1;
    i_enq_valid = 1'b0;
  endtask

  task automatic enq_when_ready(input logic [15:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (o_enq_ready) ok = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    if (ok) enq(v);
  endtask

  task automatic deq();
    i_deq_valid = 1'b1;
    @(posedge CLK); #1;
    i_deq_valid = 1'b0;
  endtask

  task automatic wait_op(output bit ok, output bit w, output bit r, output logic [15:0] d);
    ok = 1'b0; w = 1'b0; r = 1'b0; d = '0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge CLK); #1;
      if (o_pq_wrt || o_pq_read) begin
        ok = 1'b1; w = o_pq_wrt; r = o_pq_read; d = o_pq_data;
      end
    end
  endtask

  task automatic wait_resp(output bit ok, output logic [15:0] d);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge CLK); #1;
      if (o_deq_valid) begin ok = 1'b1; d = o_deq_data; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge CLK); #1;
      if (!o_busy) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTn = 1'b0; i_enq_valid = 0; i_enq_data = 0; i_deq_valid = 0; i_deq_ready = 1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (o_enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", o_enq_ready); end
    checks++; if (o_deq_ready !== 1'b1) begin errors++; $display("FAIL reset_deq_ready: got %b expected 1", o_deq_ready); end
    checks++; if (o_deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b expected 0", o_deq_valid); end
    checks++; if (o_pq_wrt !== 1'b0) begin errors++; $display("FAIL reset_pq_wrt: got %b expected 0", o_pq_wrt); end
    checks++; if (o_pq_read !== 1'b0) begin errors++; $display("FAIL reset_pq_read: got %b expected 0", o_pq_read); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    RSTn = 1'b1;
    @(posedge CLK); #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_enqueue_spacing();
    int          pc [3];
    logic [15:0] pd [3];
    int          np = 0;
    bit          saw_read = 0;
    i_enq_valid = 1'b1; i_enq_data = 16'd300;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (c == 0) i_enq_data = 16'd700;
      if (c == 1) i_enq_data = 16'd120;
      if (c == 2) i_enq_valid = 1'b0;
      if (o_pq_read) saw_read = 1'b1;
      if (o_pq_wrt) begin
        if (np < 3) begin pc[np] = c; pd[np] = o_pq_data; end
        np++;
      end
    end
    checks++; if (np != 3) begin errors++; $display("FAIL enq_pulse_count: got %0d expected 3", np); end
    if (np >= 3) begin
      checks++; if (pc[1] - pc[0] != 7) begin errors++; $display("FAIL enq_spacing_1: got %0d expected 7", pc[1]-pc[0]); end
      checks++; if (pc[2] - pc[1] != 7) begin errors++; $display("FAIL enq_spacing_2: got %0d expected 7", pc[2]-pc[1]); end
      checks++; if (pd[0] !== 16'd300) begin errors++; $display("FAIL enq_data_0: got %0d expected 300", pd[0]); end
      checks++; if (pd[1] !== 16'd700) begin errors++; $display("FAIL enq_data_1: got %0d expected 700", pd[1]); end
      checks++; if (pd[2] !== 16'd120) begin errors++; $display("FAIL enq_data_2: got %0d expected 120", pd[2]); end
    end
    checks++; if (saw_read) begin errors++; $display("FAIL enq_no_read: got 1 expected 0"); end
    checks++; if (i_pq_data !== 16'd700) begin errors++; $display("FAIL enq_root: got %0d expected 700", i_pq_data); end
  endtask

  task automatic test_dequeue();
    bit ok, w, r;
    logic [15:0] d;
    checks++; if (o_deq_ready !== 1'b1) begin errors++; $display("FAIL deq_ready_idle: got %b expected 1", o_deq_ready); end
    deq();
    wait_op(ok, w, r, d);
    checks++; if (!(ok && r && !w)) begin errors++; $display("FAIL deq_pulse: got ok=%b wrt=%b read=%b expected 1 0 1", ok, w, r); end
    wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd700) begin errors++; $display("FAIL deq_data_1: got ok=%b %0d expected 700", ok, d); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL deq_idle_1: got busy expected idle"); end
    deq();
    wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd300) begin errors++; $display("FAIL deq_data_2: got ok=%b %0d expected 300", ok, d); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL deq_idle_2: got busy expected idle"); end
  endtask

  task automatic test_replace();
    bit ok, w, r;
    logic [15:0] d;
    enq(16'd300);
    wait_op(ok, w, r, d);
    checks++; if (!(ok && w && !r)) begin errors++; $display("FAIL rep_pre_enq: got ok=%b wrt=%b read=%b expected 1 1 0", ok, w, r); end
    wait_idle(ok);
    i_enq_valid = 1'b1; i_enq_data = 16'd900; i_deq_valid = 1'b1;
    @(posedge CLK); #1;
    i_enq_valid = 1'b0; i_deq_valid = 1'b0;
    wait_op(ok, w, r, d);
    checks++; if (!(ok && w && r)) begin errors++; $display("FAIL rep_pulse: got ok=%b wrt=%b read=%b expected 1 1 1", ok, w, r); end
    checks++; if (d !== 16'd900) begin errors++; $display("FAIL rep_wdata: got %0d expected 900", d); end
    wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd300) begin errors++; $display("FAIL rep_deq_data: got ok=%b %0d expected 300", ok, d); end
    wait_idle(ok);
    checks++; if (i_pq_data !== 16'd900) begin errors++; $display("FAIL rep_root: got %0d expected 900", i_pq_data); end
  endtask

  task automatic test_empty_dequeue();
    bit ok, w, r;
    bit early = 0;
    logic [15:0] d;
    deq(); wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd900) begin errors++; $display("FAIL drain_1: got ok=%b %0d expected 900", ok, d); end
    wait_idle(ok);
    deq(); wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd120) begin errors++; $display("FAIL drain_2: got ok=%b %0d expected 120", ok, d); end
    wait_idle(ok);
    deq();
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (o_pq_wrt || o_pq_read || o_deq_valid) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL empty_deq_held: got activity expected none"); end
    checks++; if (o_deq_ready !== 1'b0) begin errors++; $display("FAIL empty_deq_pending: got deq_ready=%b expected 0", o_deq_ready); end
    enq(16'd55);
    wait_op(ok, w, r, d);
    checks++; if (!(ok && w && !r)) begin errors++; $display("FAIL empty_first_enq: got ok=%b wrt=%b read=%b expected 1 1 0", ok, w, r); end
    wait_op(ok, w, r, d);
    checks++; if (!(ok && r && !w)) begin errors++; $display("FAIL empty_then_deq: got ok=%b wrt=%b read=%b expected 1 0 1", ok, w, r); end
    wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd55) begin errors++; $display("FAIL empty_deq_data: got ok=%b %0d expected 55", ok, d); end
    wait_idle(ok);
  endtask

  task automatic test_full_stall();
    bit ok, w, r;
    bit all_ok = 1'b1;
    bit any_wrt = 1'b0;
    bit unstable = 1'b0;
    logic [15:0] d;
    for (int k = 0; k < 8; k++) begin
      enq_when_ready(16'(10 * (k + 1)), ok);
      if (!ok) all_ok = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge CLK); #1;
      if (i_pq_full && !o_busy) ok = 1'b1;
    end
    checks++; if (!(all_ok && ok)) begin errors++; $display("FAIL fill_queue: got enq_ok=%b full=%b expected 1 1", all_ok, ok); end
    for (int k = 0; k < 4; k++) enq(16'(100 + k));
    checks++; if (o_enq_ready !== 1'b0) begin errors++; $display("FAIL stall_enq_ready: got %b expected 0", o_enq_ready); end
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (o_pq_wrt) any_wrt = 1'b1;
    end
    checks++; if (any_wrt) begin errors++; $display("FAIL stall_no_wrt: got wrt pulse expected none"); end
    i_deq_ready = 1'b0;
    deq();
    wait_op(ok, w, r, d);
    checks++; if (!(ok && w && r)) begin errors++; $display("FAIL full_rep_pulse: got ok=%b wrt=%b read=%b expected 1 1 1", ok, w, r); end
    checks++; if (d !== 16'd100) begin errors++; $display("FAIL full_rep_wdata: got %0d expected 100", d); end
    wait_resp(ok, d);
    checks++; if (!ok || d !== 16'd80) begin errors++; $display("FAIL full_rep_data: got ok=%b %0d expected 80", ok, d); end
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (!o_deq_valid || o_deq_data !== 16'd80) unstable = 1'b1;
    end
    checks++; if (unstable) begin errors++; $display("FAIL resp_hold: got valid=%b data=%0d expected 1 80", o_deq_valid, o_deq_data); end
    checks++; if (o_enq_ready !== 1'b1) begin errors++; $display("FAIL drained_enq_ready: got %b expected 1", o_enq_ready); end
    checks++; if (o_deq_ready !== 1'b0) begin errors++; $display("FAIL resp_blocks_deq: got %b expected 0", o_deq_ready); end
    i_deq_ready = 1'b1;
    @(posedge CLK); #1;
    checks++; if (o_deq_valid !== 1'b0) begin errors++; $display("FAIL resp_consumed: got %b expected 0", o_deq_valid); end
  endtask

  initial begin
    test_reset();
    test_enqueue_spacing();
    test_dequeue();
    test_replace();
    test_empty_dequeue();
    test_full_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
